// File: rtl/conv_operand_streamer.sv
// Operand streamer: walks x,y,ch_in,ch_out,k_v,k_h (k_h innermost), reads one feature and one kernel word per point, zero-pads borders.
// Latency: start sampled at edge 0, reads issued from cycle 1, first valid pair in cycle 3, then one pair per cycle.
// Backpressure: 2-entry pair FIFO with a credit rule on issue; a_valid never depends on ready, head holds until accepted.
//
// Ports: clk, arst_n_in (async active-low); start/busy/done layer control;
//        fm_re/fm_addr/fm_rdata and k_re/k_addr/k_rdata to 1-cycle-latency read memories;
//        a_input/b_input with a_valid/b_valid towards the consumer, a_ready/b_ready back.
module conv_operand_streamer #(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3,
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fm_re,
  output logic [ADDR_WIDTH-1:0] fm_addr,
  input  logic [DATA_WIDTH-1:0] fm_rdata,
  output logic                  k_re,
  output logic [ADDR_WIDTH-1:0] k_addr,
  input  logic [DATA_WIDTH-1:0] k_rdata,
  output logic [DATA_WIDTH-1:0] a_input,
  output logic [DATA_WIDTH-1:0] b_input,
  output logic                  a_valid,
  output logic                  b_valid,
  input  logic                  a_ready,
  input  logic                  b_ready
);

  localparam int PAD = (KERNEL_SIZE - 1) / 2;

  localparam logic [31:0] X_LAST  = 32'(FEATURE_MAP_WIDTH - 1);
  localparam logic [31:0] Y_LAST  = 32'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [31:0] CI_LAST = 32'(INPUT_NB_CHANNELS - 1);
  localparam logic [31:0] CO_LAST = 32'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [31:0] K_LAST  = 32'(KERNEL_SIZE - 1);

  localparam logic signed [33:0] PAD_S = 34'(PAD);
  localparam logic signed [33:0] W_S   = 34'(FEATURE_MAP_WIDTH);
  localparam logic signed [33:0] H_S   = 34'(FEATURE_MAP_HEIGHT);

  localparam logic [ADDR_WIDTH-1:0] W_A  = ADDR_WIDTH'(FEATURE_MAP_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] H_A  = ADDR_WIDTH'(FEATURE_MAP_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] CI_A = ADDR_WIDTH'(INPUT_NB_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] K_A  = ADDR_WIDTH'(KERNEL_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // loop nest indices
  logic [31:0] x_q, y_q, ci_q, co_q, kv_q, kh_q;

  // FIFO of {a,b} pairs
  logic [2*DATA_WIDTH-1:0] fifo_mem [2];
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q;

  logic inflight_q;
  logic pad_q;

  logic issue;
  logic pop;
  logic push;
  logic credit_ok;
  logic last_xfer;
  logic [2:0] occ;

  // ---------------------------------------------------------------
  // Padding and addresses for the point currently addressed
  // ---------------------------------------------------------------
  logic signed [33:0] xx, yy;
  logic               padded;

  assign xx = $signed({2'b00, x_q}) + $signed({2'b00, kh_q}) - PAD_S;
  assign yy = $signed({2'b00, y_q}) + $signed({2'b00, kv_q}) - PAD_S;
  assign padded = (xx < 34'sd0) || (xx >= W_S) || (yy < 34'sd0) || (yy >= H_S);

  logic [ADDR_WIDTH-1:0] fm_addr_calc, k_addr_calc;

  assign fm_addr_calc = (ADDR_WIDTH'(ci_q) * H_A + ADDR_WIDTH'(yy)) * W_A + ADDR_WIDTH'(xx);
  assign k_addr_calc  = ((ADDR_WIDTH'(co_q) * CI_A + ADDR_WIDTH'(ci_q)) * K_A
                         + ADDR_WIDTH'(kv_q)) * K_A + ADDR_WIDTH'(kh_q);

  // addresses are forced to 0 when no read goes out, so idle/reset shows 0
  assign fm_re   = issue && !padded;
  assign k_re    = issue;
  assign fm_addr = fm_re ? fm_addr_calc : '0;
  assign k_addr  = issue ? k_addr_calc : '0;

  // ---------------------------------------------------------------
  // Counter carry chain (k_h innermost)
  // ---------------------------------------------------------------
  logic c_kh, c_kv, c_co, c_ci, c_y, last_point;

  assign c_kh       = (kh_q == K_LAST);
  assign c_kv       = c_kh && (kv_q == K_LAST);
  assign c_co       = c_kv && (co_q == CO_LAST);
  assign c_ci       = c_co && (ci_q == CI_LAST);
  assign c_y        = c_ci && (y_q == Y_LAST);
  assign last_point = c_y && (x_q == X_LAST);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      x_q  <= '0;
      y_q  <= '0;
      ci_q <= '0;
      co_q <= '0;
      kv_q <= '0;
      kh_q <= '0;
    end else if (state_q == IDLE) begin
      x_q  <= '0;
      y_q  <= '0;
      ci_q <= '0;
      co_q <= '0;
      kv_q <= '0;
      kh_q <= '0;
    end else if (issue) begin
      kh_q <= c_kh ? '0 : kh_q + 32'd1;
      if (c_kh) kv_q <= (kv_q == K_LAST)  ? '0 : kv_q + 32'd1;
      if (c_kv) co_q <= (co_q == CO_LAST) ? '0 : co_q + 32'd1;
      if (c_co) ci_q <= (ci_q == CI_LAST) ? '0 : ci_q + 32'd1;
      if (c_ci) y_q  <= (y_q == Y_LAST)   ? '0 : y_q + 32'd1;
      if (c_y)  x_q  <= (x_q == X_LAST)   ? '0 : x_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------
  // Flow control: a read may go out only if its data is guaranteed a
  // FIFO slot next cycle, counting the read already in flight.
  // ---------------------------------------------------------------
  assign a_valid   = (count_q != 2'd0);
  assign b_valid   = a_valid;
  assign pop       = a_valid && a_ready && b_ready;
  assign push      = inflight_q;
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok = (occ < 3'd2);
  assign last_xfer = pop && (count_q == 2'd1) && !inflight_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      inflight_q <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      inflight_q <= issue;
      pad_q      <= padded;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= {(pad_q ? {DATA_WIDTH{1'b0}} : fm_rdata), k_rdata};
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign a_input = fifo_mem[rd_ptr_q][2*DATA_WIDTH-1:DATA_WIDTH];
  assign b_input = fifo_mem[rd_ptr_q][DATA_WIDTH-1:0];

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (issue && last_point) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DRAIN) && last_xfer;
    issue = (state_q == STREAM) && credit_ok;
  end

endmodule

// File: tb/tb_conv_operand_streamer.sv
module tb_conv_operand_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n_in;
  logic        start_s  [2];
  logic        busy_s   [2];
  logic        done_s   [2];
  logic        fm_re_s  [2];
  logic        k_re_s   [2];
  logic [31:0] fm_addr_s[2];
  logic [31:0] k_addr_s [2];
  logic [15:0] fm_rd_s  [2];
  logic [15:0] k_rd_s   [2];
  logic [15:0] a_in_s   [2];
  logic [15:0] b_in_s   [2];
  logic        a_vld_s  [2];
  logic        b_vld_s  [2];
  logic        a_rdy_s  [2];
  logic        b_rdy_s  [2];
  int          mode     [2];

  // per-instance geometry: u_a is the small 2x2 K=3 layer, u_b a wider multi-channel one
  int cw [2] = '{2, 3};
  int ch [2] = '{2, 2};
  int cci[2] = '{1, 2};
  int cco[2] = '{1, 2};
  int ck [2] = '{3, 3};

  int n_chk = 0;
  int n_err = 0;

  conv_operand_streamer #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(1),
    .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3), .DATA_WIDTH(16), .ADDR_WIDTH(32)
  ) u_a (
    .clk(clk), .arst_n_in(arst_n_in), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .fm_re(fm_re_s[0]), .fm_addr(fm_addr_s[0]), .fm_rdata(fm_rd_s[0]),
    .k_re(k_re_s[0]), .k_addr(k_addr_s[0]), .k_rdata(k_rd_s[0]),
    .a_input(a_in_s[0]), .b_input(b_in_s[0]), .a_valid(a_vld_s[0]), .b_valid(b_vld_s[0]),
    .a_ready(a_rdy_s[0]), .b_ready(b_rdy_s[0])
  );

  conv_operand_streamer #(
    .FEATURE_MAP_WIDTH(3), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(2),
    .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3), .DATA_WIDTH(16), .ADDR_WIDTH(32)
  ) u_b (
    .clk(clk), .arst_n_in(arst_n_in), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .fm_re(fm_re_s[1]), .fm_addr(fm_addr_s[1]), .fm_rdata(fm_rd_s[1]),
    .k_re(k_re_s[1]), .k_addr(k_addr_s[1]), .k_rdata(k_rd_s[1]),
    .a_input(a_in_s[1]), .b_input(b_in_s[1]), .a_valid(a_vld_s[1]), .b_valid(b_vld_s[1]),
    .a_ready(a_rdy_s[1]), .b_ready(b_rdy_s[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // memory contents: word at address a holds a+1 (fm=[1,2,3,4], kernel=1..9 for u_a)
  function automatic logic [15:0] mem_val(input logic [31:0] a);
    return 16'(a + 32'd1);
  endfunction

  // Reference: decode a flat pair index in loop order (k_h fastest) and apply padding rules.
  function automatic void model(input int g, input int idx, output bit pad, output int fa, output int ka);
    int r, kh, kv, co, ci, y, x, p, xx, yy;
    kh = idx % ck[g];  r = idx / ck[g];
    kv = r % ck[g];    r = r / ck[g];
    co = r % cco[g];   r = r / cco[g];
    ci = r % cci[g];   r = r / cci[g];
    y  = r % ch[g];    x = r / ch[g];
    p  = (ck[g] - 1) / 2;
    xx = x + kh - p;
    yy = y + kv - p;
    pad = (xx < 0) || (xx >= cw[g]) || (yy < 0) || (yy >= ch[g]);
    fa  = pad ? 0 : (ci * ch[g] + yy) * cw[g] + xx;
    ka  = ((co * cci[g] + ci) * ck[g] + kv) * ck[g] + kh;
  endfunction

  function automatic int total(input int g);
    return cw[g] * ch[g] * cci[g] * cco[g] * ck[g] * ck[g];
  endfunction

  // 1-cycle read memories; garbage when not read so stale data would show
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      fm_rd_s[g] <= fm_re_s[g] ? mem_val(fm_addr_s[g]) : 16'hBAD0;
      k_rd_s[g]  <= k_re_s[g]  ? mem_val(k_addr_s[g])  : 16'hBAD1;
    end
  end

  // ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random per side
  initial begin
    int ph;
    ph = 0;
    for (int g = 0; g < 2; g++) begin a_rdy_s[g] = 1'b1; b_rdy_s[g] = 1'b1; end
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        case (mode[g])
          1: begin
            a_rdy_s[g] = (ph % 4 == 0) || (ph % 4 == 3);
            b_rdy_s[g] = a_rdy_s[g];
          end
          2: begin
            a_rdy_s[g] = ($urandom_range(0, 3) != 0);
            b_rdy_s[g] = ($urandom_range(0, 3) != 0);
          end
          default: begin
            a_rdy_s[g] = 1'b1;
            b_rdy_s[g] = 1'b1;
          end
        endcase
      end
      ph++;
    end
  end

  // monitor / scoreboard
  int          iss [2];
  int          xf  [2];
  int          dn  [2];
  bit          hold[2];
  logic [15:0] ha  [2];
  logic [15:0] hb  [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin : mon
      bit pad;
      int fa, ka;
      bit xfer;
      if (!arst_n_in) begin
        iss[g] = 0; xf[g] = 0; dn[g] = 0; hold[g] = 0;
      end else begin
        if (start_s[g] && !busy_s[g]) begin
          iss[g] = 0; xf[g] = 0; dn[g] = 0;
        end
        xfer = a_vld_s[g] && a_rdy_s[g] && b_rdy_s[g];
        if (busy_s[g]) chk("valid_pair", b_vld_s[g], a_vld_s[g]);
        if (fm_re_s[g]) chk("fm_re_needs_k_re", k_re_s[g], 1);
        if (k_re_s[g]) begin
          if (iss[g] >= total(g)) chk("extra_issue", iss[g], total(g) - 1);
          else begin
            model(g, iss[g], pad, fa, ka);
            chk("fm_re", fm_re_s[g], !pad);
            if (!pad) chk("fm_addr", fm_addr_s[g], fa);
            chk("k_addr", k_addr_s[g], ka);
          end
          iss[g]++;
        end
        if (hold[g]) begin
          chk("hold_valid", a_vld_s[g], 1);
          chk("hold_a", a_in_s[g], ha[g]);
          chk("hold_b", b_in_s[g], hb[g]);
        end
        if (xfer) begin
          model(g, xf[g], pad, fa, ka);
          chk("pair_a", a_in_s[g], pad ? 16'd0 : mem_val(fa));
          chk("pair_b", b_in_s[g], mem_val(ka));
          chk("done_on_last", done_s[g], xf[g] == total(g) - 1);
          xf[g]++;
        end
        if (done_s[g]) begin
          chk("done_with_xfer", xfer, 1);
          dn[g]++;
        end
        if (busy_s[g]) chk("occupancy_le2", (iss[g] - xf[g]) <= 2, 1);
        hold[g] = a_vld_s[g] && !(a_rdy_s[g] && b_rdy_s[g]);
        ha[g]   = a_in_s[g];
        hb[g]   = b_in_s[g];
      end
    end
  end

  task automatic check_reset(input int g);
    chk("rst_busy",    busy_s[g],    0);
    chk("rst_done",    done_s[g],    0);
    chk("rst_fm_re",   fm_re_s[g],   0);
    chk("rst_k_re",    k_re_s[g],    0);
    chk("rst_fm_addr", fm_addr_s[g], 0);
    chk("rst_k_addr",  k_addr_s[g],  0);
    chk("rst_a_valid", a_vld_s[g],   0);
    chk("rst_b_valid", b_vld_s[g],   0);
    chk("rst_a_input", a_in_s[g],    0);
    chk("rst_b_input", b_in_s[g],    0);
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start_s[g] = 1'b1;
    @(posedge clk); #1 start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int lim);
    bit seen;
    seen = 0;
    for (int c = 0; c < lim && !seen; c++) begin
      @(negedge clk);
      seen = done_s[g];
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("busy_after_done", busy_s[g], 0);
  endtask

  task automatic wait_xf(input int g, input int n, input int lim);
    bit ok;
    ok = 0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk); #1;
      ok = (xf[g] >= n);
    end
    chk("progress", ok, 1);
  endtask

  initial begin
    int c;
    bit got;
    arst_n_in = 1'b0;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    mode[0] = 0; mode[1] = 0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1 arst_n_in = 1'b1;

    // layer 1: ready held high, exact latency and throughput
    pulse_start(0);
    @(negedge clk);  // cycle 1
    chk("c1_k_re", k_re_s[0], 1);
    chk("c1_fm_re_pad", fm_re_s[0], 0);
    chk("c1_busy", busy_s[0], 1);
    @(negedge clk);  // cycle 2
    chk("c2_a_valid", a_vld_s[0], 0);
    @(negedge clk);  // cycle 3
    chk("c3_a_valid", a_vld_s[0], 1);
    chk("first_a", a_in_s[0], 0);
    chk("first_b", b_in_s[0], 1);
    c = 3;
    got = done_s[0];
    while (c < 200 && !got) begin
      @(negedge clk);
      c++;
      if (c == 7) begin
        chk("pair4_a", a_in_s[0], 1);
        chk("pair4_b", b_in_s[0], 5);
      end
      got = done_s[0];
    end
    chk("done_cycle", c, 38);
    @(negedge clk);
    chk("busy_low_after_done", busy_s[0], 0);
    #1;
    chk("l1_pairs", xf[0], 36);
    chk("l1_done_pulses", dn[0], 1);

    // layer 2: ready 1,0,0,1
    mode[0] = 1;
    pulse_start(0);
    wait_done(0, 1000);
    #1;
    chk("l2_pairs", xf[0], 36);
    chk("l2_done_pulses", dn[0], 1);

    // layer 3: random ready, reset mid-layer, then full restart
    mode[0] = 2;
    pulse_start(0);
    wait_xf(0, 15, 1000);
    @(posedge clk); #1 arst_n_in = 1'b0;
    @(negedge clk);
    check_reset(0);
    @(posedge clk); #1 arst_n_in = 1'b1;
    pulse_start(0);
    wait_done(0, 1000);
    #1;
    chk("l3_pairs", xf[0], 36);
    chk("l3_done_pulses", dn[0], 1);

    // layer 4: larger layer, random ready, start pulsed while busy
    mode[1] = 2;
    pulse_start(1);
    wait_xf(1, 50, 2000);
    pulse_start(1);
    wait_done(1, 5000);
    #1;
    chk("l4_pairs", xf[1], total(1));
    chk("l4_done_pulses", dn[1], 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
